// File: rtl/output_vc_allocator.sv
// Output VC allocator for one router output port.
// Each cycle at most one eligible requester is granted the lowest-index free output VC.
// A VC is returned to the free pool when a TAIL flit fires on it.
// Optional macro VA_ROUND_ROBIN_EN selects rotating requester priority.
// Without it, priority is fixed and the lowest index always wins.
module output_vc_allocator #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned N_VC  = 2,
    localparam int unsigned REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned VC_W  = (N_VC > 1) ? $clog2(N_VC) : 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [2*N_VC-1:0] vc_flit_type_i,
    input  logic [N_VC-1:0]   vc_flit_fire_i,
    output logic [N_REQ-1:0]  grant_o,
    output logic [VC_W-1:0]   grant_vc_o,
    output logic [N_VC-1:0]   out_vc_available_o,
    output logic [N_REQ-1:0]  req_busy_o
);

    // TAIL encoding, matching the router-wide flit type definitions.
    localparam logic [1:0] FlitTail = 2'b10;

    logic [N_VC-1:0]  avail_q, avail_d;
    logic [REQ_W-1:0] owner_q [N_VC];
    logic [REQ_W-1:0] owner_d [N_VC];
    logic [N_REQ-1:0] busy_q, busy_d;
    logic [REQ_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [VC_W-1:0]  grant_vc_q, grant_vc_d;

    logic [N_REQ-1:0] elig;
    logic [REQ_W-1:0] cand;
    logic [REQ_W-1:0] win_idx;
    logic             win_found;
    logic [VC_W-1:0]  vc_idx;
    logic             alloc;

    // Winner: first eligible requester searching circularly from ptr.
    always_comb begin
        elig      = req_i & ~busy_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = REQ_W'((32'(ptr_q) + k) % N_REQ);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Chosen VC: lowest-index free VC (pre-edge availability only).
    always_comb begin
        vc_idx = '0;
        for (int i = int'(N_VC) - 1; i >= 0; i--) begin
            if (avail_q[i]) begin
                vc_idx = VC_W'(i);
            end
        end
    end

    assign alloc = win_found && (|avail_q);

    // Next state: apply all TAIL releases, then the (disjoint) allocation.
    always_comb begin
        avail_d    = avail_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        grant_d    = '0;
        grant_vc_d = grant_vc_q;
        ptr_d      = ptr_q;

        for (int unsigned i = 0; i < N_VC; i++) begin
            // Releasing an already free VC must not clear a stale owner's busy bit.
            if (vc_flit_fire_i[i] && (vc_flit_type_i[2*i +: 2] == FlitTail) && !avail_q[i]) begin
                avail_d[i]             = 1'b1;
                busy_d[owner_q[i]]     = 1'b0;
            end
        end

        if (alloc) begin
            avail_d[vc_idx] = 1'b0;
            owner_d[vc_idx] = win_idx;
            busy_d[win_idx] = 1'b1;
            grant_d[win_idx] = 1'b1;
            grant_vc_d      = vc_idx;
`ifdef VA_ROUND_ROBIN_EN
            ptr_d = (win_idx == REQ_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end

`ifndef VA_ROUND_ROBIN_EN
        ptr_d = '0;
`endif
    end

    // State registers; reset drops all ownership asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            avail_q    <= '1;
            busy_q     <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_vc_q <= '0;
            for (int unsigned i = 0; i < N_VC; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            avail_q    <= avail_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_vc_q <= grant_vc_d;
            for (int unsigned i = 0; i < N_VC; i++) begin
                owner_q[i] <= owner_d[i];
            end
        end
    end

    assign grant_o            = grant_q;
    assign grant_vc_o         = grant_vc_q;
    assign out_vc_available_o = avail_q;
    assign req_busy_o         = busy_q;

endmodule

// File: tb/tb_output_vc_allocator.sv
// Self-checking bench for output_vc_allocator (N_REQ=4, N_VC=2).
// A table-level model tracks free VCs, owners and busy requesters; a compare process
// checks every output each cycle, and directed steps pin hand-computed values.
module tb_output_vc_allocator;

    localparam int NR = 4;
    localparam int NV = 2;
    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NR-1:0] req;
    logic [3:0]    vtype;
    logic [NV-1:0] fire;
    logic [NR-1:0] grant;
    logic          grant_vc;
    logic [NV-1:0] avail;
    logic [NR-1:0] busy;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    // Reference model state
    bit          m_avail [NV];
    int          m_owner [NV];
    bit          m_busy  [NR];
    int          m_ptr;
    logic [NR-1:0] m_grant;
    logic        m_gvc;

    always #5 clk = ~clk;

    output_vc_allocator #(.N_REQ(NR), .N_VC(NV)) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .req_i              (req),
        .vc_flit_type_i     (vtype),
        .vc_flit_fire_i     (fire),
        .grant_o            (grant),
        .grant_vc_o         (grant_vc),
        .out_vc_available_o (avail),
        .req_busy_o         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NV-1:0] m_avail_vec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_avail[i];
        return v;
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin m_avail[i] = 1'b1; m_owner[i] = 0; end
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_ptr = 0; m_grant = '0; m_gvc = 1'b0;
    endtask

    // One clock edge of the allocator rules, from pre-edge state and inputs.
    task automatic model_step();
        int  w = -1;
        int  v = -1;
        bit  na [NV];
        int  no [NV];
        bit  nb [NR];
        for (int k = 0; k < NR; k++) begin
            int idx = (m_ptr + k) % NR;
            if (w < 0 && req[idx] && !m_busy[idx]) w = idx;
        end
        for (int i = 0; i < NV; i++) if (v < 0 && m_avail[i]) v = i;
        na = m_avail; no = m_owner; nb = m_busy;
        for (int i = 0; i < NV; i++) begin
            if (fire[i] && vtype[2*i +: 2] == T_TAIL && !m_avail[i]) begin
                na[i] = 1'b1;
                nb[m_owner[i]] = 1'b0;
            end
        end
        if (w >= 0 && v >= 0) begin
            na[v] = 1'b0; no[v] = w; nb[w] = 1'b1;
            m_grant = NR'(1) << w;
            m_gvc = (v == 1);
`ifdef VA_ROUND_ROBIN_EN
            m_ptr = (w + 1) % NR;
`endif
        end else begin
            m_grant = '0;
        end
        m_avail = na; m_owner = no; m_busy = nb;
    endtask

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (run && rstn) begin
            chk("cmp_grant", 32'(grant), 32'(m_grant));
            chk("cmp_grant_vc", 32'(grant_vc), 32'(m_gvc));
            chk("cmp_avail", 32'(avail), 32'(m_avail_vec()));
            chk("cmp_busy", 32'(busy), 32'(m_busy_vec()));
        end
    end

    task automatic cyc(input logic [3:0] r, input logic [1:0] f, input logic [1:0] t0,
                       input logic [1:0] t1);
        req = r; fire = f; vtype = {t1, t0};
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_avail", 32'(avail), 32'h3);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_grant_vc", 32'(grant_vc), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req = '0; fire = '0; vtype = '0;
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
    endtask

    logic [3:0] fair_exp;

    initial begin
        rstn = 1'b0; req = '0; fire = '0; vtype = '0;
        model_reset();
        run = 1'b1;
        @(negedge clk);
        do_reset();

        // Single request
        cyc(4'b0100, 2'b00, T_HEAD, T_HEAD);
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_vc", 32'(grant_vc), 32'h0);
        chk("single_avail", 32'(avail), 32'h2);
        chk("single_busy", 32'(busy), 32'h4);
        cyc(4'b0000, 2'b00, T_HEAD, T_HEAD);
        chk("grant_pulse", 32'(grant), 32'h0);
        cyc(4'b0000, 2'b01, T_TAIL, T_HEAD);
        chk("rel0_avail", 32'(avail), 32'h3);

        // Contention from a fresh pointer
        do_reset();
        cyc(4'b1111, 2'b00, T_HEAD, T_HEAD);
        chk("cont1_grant", 32'(grant), 32'h1);
        chk("cont1_vc", 32'(grant_vc), 32'h0);
        cyc(4'b1111, 2'b00, T_HEAD, T_HEAD);
        chk("cont2_grant", 32'(grant), 32'h2);
        chk("cont2_vc", 32'(grant_vc), 32'h1);
        cyc(4'b1111, 2'b00, T_HEAD, T_HEAD);
        chk("cont3_none", 32'(grant), 32'h0);
        chk("cont3_vc_hold", 32'(grant_vc), 32'h1);
        cyc(4'b1111, 2'b00, T_HEAD, T_HEAD);
        chk("cont4_busy", 32'(busy), 32'h3);

        // Release VC1 (owner 1) while req[3] waits
        cyc(4'b1000, 2'b10, T_HEAD, T_TAIL);
        chk("rel1_grant", 32'(grant), 32'h0);
        chk("rel1_avail", 32'(avail), 32'h2);
        chk("rel1_busy", 32'(busy), 32'h1);
        cyc(4'b1000, 2'b00, T_HEAD, T_HEAD);
        chk("after_rel_grant", 32'(grant), 32'h8);
        chk("after_rel_vc", 32'(grant_vc), 32'h1);
        cyc(4'b0000, 2'b10, T_HEAD, T_BODY);
        chk("body_avail", 32'(avail), 32'h0);
        chk("body_busy", 32'(busy), 32'h9);

        // Asynchronous reset mid-operation
        rstn = 1'b0;
        #1;
        model_reset();
        chk("midrst_avail", 32'(avail), 32'h3);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_vc", 32'(grant_vc), 32'h0);
        req = '0; fire = '0;
        @(negedge clk);
        #1 rstn = 1'b1;

        // Simultaneous release and allocation
        cyc(4'b0010, 2'b00, T_HEAD, T_HEAD);
        cyc(4'b0100, 2'b00, T_HEAD, T_HEAD);
        cyc(4'b0000, 2'b01, T_TAIL, T_HEAD);
        chk("setup_avail", 32'(avail), 32'h1);
        cyc(4'b1000, 2'b10, T_HEAD, T_TAIL);
        chk("simul_grant", 32'(grant), 32'h8);
        chk("simul_vc", 32'(grant_vc), 32'h0);
        chk("simul_avail", 32'(avail), 32'h2);
        chk("simul_busy", 32'(busy), 32'h8);

        // Owner re-requests on the cycle its VC is released: masked for that cycle
        cyc(4'b1000, 2'b01, T_TAIL, T_HEAD);
        chk("remask_grant", 32'(grant), 32'h0);
        chk("remask_avail", 32'(avail), 32'h3);
        cyc(4'b1000, 2'b00, T_HEAD, T_HEAD);
        chk("regrant", 32'(grant), 32'h8);
        chk("regrant_vc", 32'(grant_vc), 32'h0);

        // Multiple releases in one cycle, then releases of free VCs
        cyc(4'b0100, 2'b00, T_HEAD, T_HEAD);
        chk("multi_setup_busy", 32'(busy), 32'hC);
        cyc(4'b0000, 2'b11, T_TAIL, T_TAIL);
        chk("multi_avail", 32'(avail), 32'h3);
        chk("multi_busy", 32'(busy), 32'h0);
        cyc(4'b0000, 2'b11, T_TAIL, T_TAIL);
        chk("free_rel_avail", 32'(avail), 32'h3);

        // Fairness: after requester 0 is served, 1001 picks 3 only with rotation
        do_reset();
        cyc(4'b0001, 2'b00, T_HEAD, T_HEAD);
        cyc(4'b0000, 2'b01, T_TAIL, T_HEAD);
        cyc(4'b1001, 2'b00, T_HEAD, T_HEAD);
`ifdef VA_ROUND_ROBIN_EN
        fair_exp = 4'b1000;
`else
        fair_exp = 4'b0001;
`endif
        chk("fair_grant", 32'(grant), 32'(fair_exp));
        chk("fair_vc", 32'(grant_vc), 32'h0);

        cyc(4'b0000, 2'b00, T_HEAD, T_HEAD);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_vc_allocator.md
# output_vc_allocator

Allocates the output VCs of one router output port among the input-VC requesters of that port. Each cycle it picks at most one requester, grants it the lowest-index free output VC, and marks that VC busy. The VC is released when a TAIL flit fires on it. The block also records which requester owns each VC. It sits between the input-stage route logic and the per-VC output-stage availability flags, and replaces per-VC set/clear control with one centralized allocator.

## Interface
Parameters:
- N_REQ, 4, number of requesters (input VCs competing for this output port); ≥2
- N_VC, 2, number of output VCs on this port; ≥1
- Derived localparams: REQ_W = max(1, clog2(N_REQ)), VC_W = max(1, clog2(N_VC))

Ports:
- clk  input  1  clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- req  input  N_REQ  level request per requester; held until granted
- vc_flit_type  input  2*N_VC  flit type per output VC, bits [2i+1:2i] for VC i; encoding per params.vh (`HEAD/`BODY/`TAIL)
- vc_flit_fire  input  N_VC  flit transferred on output VC i this cycle
- grant  output  N_REQ  registered one-hot grant pulse, one cycle
- grant_vc  output  VC_W  index of the granted VC; valid only while |grant
- out_vc_available  output  N_VC  registered per-VC free flag
- req_busy  output  N_REQ  requester i currently owns a VC

## Operation
- State held per VC: available bit and owner index (REQ_W).
- State held per requester: busy bit.
- State held globally: priority pointer ptr (REQ_W).
- Eligible requests: elig = req & ~req_busy.
- Allocation happens when |elig is true and at least one bit of out_vc_available is set:
  - Winner w is the first set bit of elig, searching circularly from ptr.
  - Chosen VC v is the lowest-index set bit of out_vc_available.
  - On the edge: grant is one-hot w, grant_vc is v, available[v] is cleared, owner[v] is set to w, busy[w] is set.
- No allocation when elig is 0 or no VC is free. grant is then 0, grant_vc holds its last value, and ptr is unchanged.
- Release fires for VC i on a cycle where vc_flit_fire[i] is set and vc_flit_type for i equals `TAIL.
  - On that edge: available[i] is set and busy[owner[i]] is cleared.
  - A release on a VC that is already available has no effect.
- Multiple releases in one cycle are all applied.
- Release and allocation in the same cycle:
  - Allocation uses the pre-edge availability, so a VC being released cannot be granted that same cycle. It is grantable from the next cycle.
  - Because a VC being released is never free before the edge, a release and an allocation can never target the same VC.
- Requester whose VC is released in the same cycle it requests again: it stays masked in that cycle and becomes eligible in the next cycle.
- At most one grant per cycle, even when several VCs are free.

## Timing
- Reset values: out_vc_available all 1s, grant 0, grant_vc 0, req_busy 0, ptr 0, all owners 0.
- Request latency: req sampled high at edge t produces grant high for the cycle after edge t, and grant falls at edge t+1.
- out_vc_available[v] and req_busy[w] update on the same edge as the grant.
- Release latency: a TAIL fire sampled at edge t sets out_vc_available[i] after edge t.
- Worst-case time from release to new grant: one release edge plus one allocation edge.
- A requester may drop req while the grant is visible. If req stays high, busy masks it, so no double grant occurs.
- Reset mid-operation: all ownership is lost immediately and asynchronously. Upstream must also be in reset.

## Configuration
- Macro VA_ROUND_ROBIN_EN.
- Defined: rotating priority. After a grant to w, ptr becomes (w+1) mod N_REQ.
- Undefined: fixed priority. ptr is held at 0, so the lowest-index eligible requester always wins. Starvation is possible and acceptable in this mode.
- VC selection (lowest free index) is the same in both modes.

## Test plan
All scenarios use N_REQ=4, N_VC=2.
- Reset: rstn low then high -> out_vc_available=2'b11, grant=0, req_busy=0.
- Single request: req=4'b0100 for one cycle -> next cycle grant=4'b0100, grant_vc=0, out_vc_available=2'b10, req_busy=4'b0100.
- Contention: req=4'b1111 held four cycles with VA_ROUND_ROBIN_EN defined -> grants 0001 (VC0), then 0010 (VC1), then none while no VC is free. Without the macro, the same two grants occur in index order and the pointer stays 0.
- Release:
  - Setup: VC1 owned by requester 1. Apply vc_flit_fire=2'b10 with the VC1 type=`TAIL.
  - Expected: out_vc_available[1]=1 and req_busy[1]=0 next cycle; a pending req[3] is granted VC1 one cycle after that.
  - `BODY fire on VC1 -> no change.
- Simultaneous events: VC0 free, VC1 receives a TAIL fire, req=4'b1000 in the same cycle -> grant to requester 3 with grant_vc=0, and VC1 becomes available after the same edge.
- Fairness, macro defined: after requester 0 is granted and released, keep req=4'b1001 -> the next grant goes to requester 3, not 0.
